// File: rtl/lpc_capture_sched.sv
// Captures decoded LPC transactions inside an address window into a small FIFO
// and serializes each record as four bytes over a valid/ready byte stream.
module lpc_capture_sched #(
    parameter int DEPTH = 4
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        in_latch,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_addr_lo,
    input  logic [15:0] cfg_addr_hi,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  fifo_level,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [27:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic          latch_q;
    logic          overflow_q;
    logic [7:0]    drop_count_q;

    logic          evt, in_window, accept, full, do_pop, do_write, do_drop;
    logic [27:0]   record, head;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^in_addr[31:16];

    assign evt       = in_latch && !latch_q;
    assign in_window = (in_addr[15:0] >= cfg_addr_lo) && (in_addr[15:0] <= cfg_addr_hi);
    assign accept    = evt && cfg_enable && in_window;
    assign full      = (count_q == 5'(DEPTH));
    assign do_pop    = (state_q == S_SEND) && out_ready && (byte_idx_q == 2'd3);
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the write.
    assign do_write  = accept && (!full || do_pop);
    assign do_drop   = accept && full && !do_pop;
    assign record    = {in_cyctype_dir, in_addr[15:0], in_data};
    assign head      = mem_q[rd_ptr_q];

    assign count_d = count_q + {4'b0, do_write} - {4'b0, do_pop};

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    state_d    = S_SEND;
                    byte_idx_d = 2'd0;
                end
            end
            default: begin
                if (out_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d    = S_IDLE;
                        byte_idx_d = 2'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        out_byte = 8'h00;
        if (state_q == S_SEND) begin
            case (byte_idx_q)
                2'd0:    out_byte = {4'h0, head[27:24]};
                2'd1:    out_byte = head[23:16];
                2'd2:    out_byte = head[15:8];
                default: out_byte = head[7:0];
            endcase
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= record;
        end
    end

    // latch_q resets high so a latch already asserted at release is not an edge.
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            latch_q      <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 5'd0;
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            latch_q    <= in_latch;
            count_q    <= count_d;
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
        end
    end

    assign out_valid  = (state_q == S_SEND);
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/lpc_capture_sched.md
LPC_CAPTURE_SCHED -- requirements
Module: lpc_capture_sched

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, meaning number of record entries in the internal FIFO (power of two, 2..16).
- REQ-002 SHALL have port lpc_clock  input  1  single clock; all state changes on its rising edge.
- REQ-003 SHALL have port lpc_reset  input  1  reset; asynchronous and active-high.
- REQ-004 SHALL have port in_cyctype_dir  input  4  cycle type/direction from the LPC decoder.
- REQ-005 SHALL have port in_addr  input  32  decoded address; only bits [15:0] are used.
- REQ-006 SHALL have port in_data  input  8  decoded data byte.
- REQ-007 SHALL have port in_latch  input  1  decoder latch; its rising edge marks a completed transaction.
- REQ-008 SHALL have port cfg_enable  input  1  capture enable.
- REQ-009 SHALL have ports cfg_addr_lo and cfg_addr_hi  input  16 each  inclusive address window.
- REQ-010 SHALL have port out_byte  output  8  serialized record byte.
- REQ-011 SHALL have port out_valid  output  1  out_byte valid.
- REQ-012 SHALL have port out_ready  input  1  downstream (UART) accepts out_byte.
- REQ-013 SHALL have port fifo_level  output  5  current FIFO entry count.
- REQ-014 SHALL have port overflow  output  1  sticky flag; a record was dropped.
- REQ-015 SHALL have port drop_count  output  8  saturating count of dropped records.

Function
- REQ-016 SHALL register in_latch into latch_d; an event SHALL occur in any cycle with in_latch=1 and latch_d=0.
- REQ-017 An event SHALL be accepted only if cfg_enable=1 and cfg_addr_lo <= in_addr[15:0] <= cfg_addr_hi (unsigned); lo>hi SHALL accept nothing.
- REQ-018 Filtering SHALL use cfg_* and in_* values sampled in the event cycle.
- REQ-019 An accepted event SHALL store record {in_cyctype_dir, in_addr[15:0], in_data} at the end of the event cycle; fifo_level SHALL increase by one in the next cycle.
- REQ-020 If an accepted event finds the FIFO full and no pop occurs in that cycle, the record SHALL be dropped, overflow SHALL be set, and drop_count SHALL increment, saturating at 255.
- REQ-021 If the FIFO is full and a pop occurs in the same cycle as an accepted event, the write SHALL succeed; fifo_level SHALL be unchanged and there SHALL be no drop.
- REQ-022 FIFO pointers SHALL wrap modulo DEPTH; records SHALL leave in arrival order.
- REQ-023 The serializer FSM SHALL have two states: IDLE and SEND.
- REQ-024 IDLE: out_valid=0; if fifo_level>0, the FSM SHALL go to SEND with byte_idx=0.
- REQ-025 SEND: out_valid=1, with out_byte selected by byte_idx: 0 -> {4'h0, cyctype_dir}; 1 -> addr[15:8]; 2 -> addr[7:0]; 3 -> data.
- REQ-026 In SEND, out_byte SHALL be held stable while out_valid=1 and out_ready=0.
- REQ-027 On out_valid&&out_ready with byte_idx<3, byte_idx SHALL increment.
- REQ-028 On out_valid&&out_ready with byte_idx=3, the head entry SHALL be popped and the FSM SHALL return to IDLE.
- REQ-029 Minimum gap between records SHALL be one IDLE cycle; latency from event cycle to first out_valid SHALL be 2 cycles when the FIFO is empty.
- REQ-030 Changes to cfg_* SHALL NOT affect records already queued or in transmission.

Reset
- REQ-031 While lpc_reset=1: state=IDLE, byte_idx=0, FIFO empty, fifo_level=0, out_valid=0, out_byte=0, overflow=0, drop_count=0.
- REQ-032 While lpc_reset=1, latch_d SHALL be 1, so a latch already high at reset release SHALL create no event.
- REQ-033 Reset mid-record SHALL discard the partial record and all queued records; after release, the first out_valid SHALL require a new event.

Verification
- REQ-034 Window 0x0080..0x0080, enable=1, event addr=0x0080 data=0x5A cyc=0x2, out_ready=1 -> bytes 0x02,0x00,0x80,0x5A on 4 consecutive cycles, first at event+2.
- REQ-035 Events at addr 0x007F, then 0x0081, then enable=0 with addr 0x0080 -> no out_valid, fifo_level stays 0, overflow=0.
- REQ-036 DEPTH=4, out_ready=0, 6 accepted events -> fifo_level=4, overflow=1, drop_count=2, out_byte frozen at first record byte 0.
- REQ-037 FIFO full and in SEND with byte_idx=3; out_ready=1 in the same cycle as a new event -> fifo_level stays 4, drop_count unchanged, new record emitted last.
- REQ-038 in_latch held high for 10 cycles -> exactly one record; in_latch high across reset release -> zero records.
- REQ-039 Assert lpc_reset during byte_idx=2 with 3 records queued -> out_valid=0 and fifo_level=0 immediately; no bytes emitted after release until a new event.
